fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port stall  input  1  decode hazard; freeze PC and ID outputs.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump taken, from decode.
REQ-005 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-006 SHALL have port imem_ready  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port imem_req  output  1  fetch request.
REQ-009 SHALL have port imem_addr  output  32  fetch address (= PC).
REQ-010 SHALL have port id_valid  output  1  ID register holds a real instruction.
REQ-011 SHALL have port id_inst  output  32  latched instruction.
REQ-012 SHALL have port id_pc_plus4  output  32  PC of id_inst plus 4.
REQ-013 SHALL have port id_imm16  output  16  id_inst[15:0]; drives signext inst input.
REQ-014 SHALL have ports id_rs, id_rt, id_rd  output  5 each  id_inst[25:21], [20:16], [15:11].

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, SLOT; FETCH is the first state after reset release.
REQ-016 imem_req SHALL be 1 in FETCH and SLOT, 0 in HOLD and in reset; imem_addr SHALL equal PC always.
REQ-017 Fetch completes when imem_req & imem_ready & !stall; next edge: id_inst<=imem_rdata, id_pc_plus4<=PC+4, id_valid<=1, PC<=PC+4 (1-cycle latency).
REQ-018 imem_ready=0 with no stall SHALL insert a bubble: id_valid<=0, PC holds.
REQ-019 stall=1 (no redirect) SHALL hold PC and all id_* registers, and move FSM to HOLD; stall=0 in HOLD returns to FETCH.
REQ-020 redirect_valid SHALL have priority over stall for PC update; redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 id_imm16, id_rs, id_rt, id_rd SHALL be combinational slices of id_inst, no added latency.

Reset
REQ-023 rst_n=0 SHALL asynchronously set PC=RESET_PC, FSM=FETCH, id_valid=0, id_inst=0, id_pc_plus4=0, pending target=0.
REQ-024 Reset asserted mid-fetch or in SLOT SHALL discard any pending response or target; no completion after release until a new imem_ready.

Configuration
REQ-025 Macro DELAY_SLOT_EN defined: one delay slot; redirect cycle with completing fetch keeps that instruction, PC<=redirect_pc; without completing fetch, target latched, FSM->SLOT, next completed fetch (the slot) latched, then PC<=target, FSM->FETCH.
REQ-026 In SLOT a new redirect_valid SHALL overwrite the latched target.
REQ-027 DELAY_SLOT_EN undefined: redirect SHALL flush (id_valid<=0, fetch in that cycle discarded), PC<=redirect_pc, SLOT never entered.

Structure
REQ-028 Package mips_pkg SHALL hold RESET_PC (32'h0000_0000), instruction field bit positions, and the FSM state enum.
REQ-029 PC register with increment/redirect mux SHALL be sub-module pc_reg; FSM and ID register stay in fetch_stage.

Verification
REQ-030 Reset, imem_ready=1 always, rdata=32'h2001_0011 -> imem_addr 0,4,8; id_pc_plus4=4 one cycle after first ready; id_imm16=16'h0011, id_rt=1.
REQ-031 imem_ready low for 2 cycles at PC=8 -> id_valid=0 two cycles, PC stays 8, resumes 12.
REQ-032 stall 3 cycles with id_inst=32'h2001_FFFF -> imem_req=0, id_inst and PC unchanged, id_imm16=16'hFFFF held.
REQ-033 No DELAY_SLOT_EN, redirect_pc=32'h0000_0103 at PC=16 -> id_valid=0 next cycle, imem_addr=32'h0000_0100.
REQ-034 DELAY_SLOT_EN, redirect at PC=16 with imem_ready=0 -> SLOT; slot word from 16 latched with id_valid=1, then imem_addr=32'h0000_0100.
REQ-035 PC=32'hFFFF_FFFC, fetch completes -> id_pc_plus4=0, imem_addr=0; rst_n pulsed low mid-SLOT -> all outputs zero immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared reset PC, instruction field positions and fetch FSM states.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SLOT  = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : Program counter with word-aligned load and +4 increment.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_load_aligned;

    assign w_load_aligned = load_pc & 32'hFFFF_FFFC;
    // Natural 32-bit overflow gives the required wrap to zero.
    assign pc_plus4       = r_pc + 32'd4;
    assign pc             = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= w_load_aligned;
        end else if (inc) begin
            r_pc <= pc_plus4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch FSM plus IF/ID register. Define DELAY_SLOT_EN
//           for one branch delay slot; otherwise redirects flush the fetch.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc_plus4,
    output logic [15:0] id_imm16,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_fire;
    logic        w_pc_load;
    logic        w_pc_inc;
    logic [31:0] w_load_pc;
    logic        w_id_load;
    logic        w_id_clear;

    logic        r_id_valid;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc_plus4;

`ifdef DELAY_SLOT_EN
    logic [31:0] r_target;
    logic [31:0] w_target_next;
`endif

    // Request is suppressed while reset is held, not just after the edge.
    assign imem_req  = rst_n & (r_state != ST_HOLD);
    assign imem_addr = w_pc;
    assign w_fire    = imem_req & imem_ready & ~stall;

    pc_reg u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_pc_load),
        .inc      (w_pc_inc),
        .load_pc  (w_load_pc),
        .pc       (w_pc),
        .pc_plus4 (w_pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_load     = 1'b0;
        w_pc_inc      = 1'b0;
        w_load_pc     = redirect_pc;
        w_id_load     = 1'b0;
        w_id_clear    = 1'b0;
`ifdef DELAY_SLOT_EN
        w_target_next = r_target;
        if (r_state == ST_SLOT) begin
            // A later redirect replaces the pending target before it is used.
            if (redirect_valid) begin
                w_target_next = redirect_pc & 32'hFFFF_FFFC;
            end
            if (w_fire) begin
                w_id_load    = 1'b1;
                w_pc_load    = 1'b1;
                w_load_pc    = w_target_next;
                w_state_next = ST_FETCH;
            end else if (!stall) begin
                w_id_clear   = 1'b1;
            end
        end else if (redirect_valid) begin
            if (w_fire) begin
                w_id_load    = 1'b1;
                w_pc_load    = 1'b1;
                w_state_next = ST_FETCH;
            end else begin
                w_target_next = redirect_pc & 32'hFFFF_FFFC;
                w_state_next  = ST_SLOT;
                w_id_clear    = ~stall;
            end
        end else
`else
        if (redirect_valid) begin
            w_id_clear   = 1'b1;
            w_pc_load    = 1'b1;
            w_state_next = ST_FETCH;
        end else
`endif
        if (stall) begin
            w_state_next = ST_HOLD;
        end else if (w_fire) begin
            w_id_load    = 1'b1;
            w_pc_inc     = 1'b1;
            w_state_next = ST_FETCH;
        end else begin
            w_id_clear   = 1'b1;
            w_state_next = ST_FETCH;
        end
    end

`ifdef DELAY_SLOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= 32'h0;
        end else begin
            r_target <= w_target_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid    <= 1'b0;
            r_id_inst     <= 32'h0;
            r_id_pc_plus4 <= 32'h0;
        end else if (w_id_load) begin
            r_id_valid    <= 1'b1;
            r_id_inst     <= imem_rdata;
            r_id_pc_plus4 <= w_pc_plus4;
        end else if (w_id_clear) begin
            r_id_valid    <= 1'b0;
        end
    end

    assign id_valid    = r_id_valid;
    assign id_inst     = r_id_inst;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_imm16    = r_id_inst[IMM_MSB:IMM_LSB];
    assign id_rs       = r_id_inst[RS_MSB:RS_LSB];
    assign id_rt       = r_id_inst[RT_MSB:RT_LSB];
    assign id_rd       = r_id_inst[RD_MSB:RD_LSB];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Scoreboard bench for fetch_stage; honours DELAY_SLOT_EN if defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc_plus4    (id_pc_plus4),
        .id_imm16       (id_imm16),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] p4;
    } snap_t;

    snap_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: architectural PC, decode-held flag, pending delay-slot target.
    logic [31:0] m_pc;
    bit          m_hold;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_p4;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_latch(logic [31:0] rd);
        m_inst  = rd;
        m_p4    = m_pc + 32'd4;
        m_valid = 1'b1;
    endtask

    task automatic model_step(bit rst, bit st, bit rv, logic [31:0] rpc, bit rdy, logic [31:0] rd);
        logic [31:0] tgt;
        bit          req;
        bit          fire;
        if (!rst) begin
            m_pc = 32'h0; m_hold = 0; m_pend = 0; m_tgt = 32'h0;
            m_valid = 0; m_inst = 32'h0; m_p4 = 32'h0;
            return;
        end
        tgt  = {rpc[31:2], 2'b00};
        req  = m_pend || !m_hold;
        fire = req && rdy && !st;
`ifdef DELAY_SLOT_EN
        if (m_pend) begin
            if (rv) m_tgt = tgt;
            if (fire) begin
                model_latch(rd);
                m_pc   = m_tgt;
                m_pend = 0;
            end else if (!st) begin
                m_valid = 0;
            end
        end else if (rv) begin
            m_hold = 0;
            if (fire) begin
                model_latch(rd);
                m_pc = tgt;
            end else begin
                m_tgt  = tgt;
                m_pend = 1;
                if (!st) m_valid = 0;
            end
        end else
`else
        if (rv) begin
            m_valid = 0;
            m_pc    = tgt;
            m_hold  = 0;
        end else
`endif
        if (st) begin
            m_hold = 1;
        end else if (fire) begin
            model_latch(rd);
            m_pc   = m_pc + 32'd4;
            m_hold = 0;
        end else begin
            m_valid = 0;
            m_hold  = 0;
        end
    endtask

    // Called at a negedge: drive, predict the post-edge outputs, advance to next negedge.
    task automatic step(bit rst, bit st, bit rv, logic [31:0] rpc, bit rdy, logic [31:0] rd);
        snap_t e;
        rst_n          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_rdata     = rd;
        model_step(rst, st, rv, rpc, rdy, rd);
        e.req   = rst && (m_pend || !m_hold);
        e.addr  = m_pc;
        e.valid = m_valid;
        e.inst  = m_inst;
        e.p4    = m_p4;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr,         32'h0);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_inst"},  id_inst,           32'h0);
        chk({tag, "_p4"},    id_pc_plus4,       32'h0);
        chk({tag, "_flds"},  {id_imm16, 1'b0, id_rs, id_rt, id_rd}, 32'h0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_step(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_req",   {31'h0, imem_req}, {31'h0, e.req});
                chk("sb_addr",  imem_addr,         e.addr);
                chk("sb_valid", {31'h0, id_valid}, {31'h0, e.valid});
                if (e.valid) begin
                    chk("sb_inst",  id_inst,            e.inst);
                    chk("sb_p4",    id_pc_plus4,        e.p4);
                    chk("sb_imm16", {16'h0, id_imm16},  {16'h0, e.inst[15:0]});
                    chk("sb_rs",    {27'h0, id_rs},     {27'h0, e.inst[25:21]});
                    chk("sb_rt",    {27'h0, id_rt},     {27'h0, e.inst[20:16]});
                    chk("sb_rd",    {27'h0, id_rd},     {27'h0, e.inst[15:11]});
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
        model_step(0, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        check_all_zero("reset");
        step(0, 0, 0, 32'h0, 1, 32'h2001_0011);

        // Straight-line fetch
        step(1, 0, 0, 32'h0, 1, 32'h2001_0011);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_p4_4",  id_pc_plus4, 32'h4);
        chk("seq_imm",   {16'h0, id_imm16}, 32'h0011);
        chk("seq_rt",    {27'h0, id_rt}, 32'h1);
        step(1, 0, 0, 32'h0, 1, 32'h2001_0011);
        chk("seq_addr8", imem_addr, 32'h8);

        // Two-cycle memory wait
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("bub1_valid", {31'h0, id_valid}, 32'h0);
        chk("bub1_addr",  imem_addr, 32'h8);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("bub2_valid", {31'h0, id_valid}, 32'h0);
        chk("bub2_addr",  imem_addr, 32'h8);
        step(1, 0, 0, 32'h0, 1, 32'h1111_2222);
        chk("resume_addr", imem_addr, 32'hC);

        // Decode stall holds everything
        step(1, 0, 0, 32'h0, 1, 32'h2001_FFFF);
        step(1, 1, 0, 32'h0, 1, 32'h3333_3333);
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        step(1, 1, 0, 32'h0, 1, 32'h3333_3333);
        step(1, 1, 0, 32'h0, 1, 32'h3333_3333);
        chk("stall_req3",  {31'h0, imem_req}, 32'h0);
        chk("stall_inst",  id_inst, 32'h2001_FFFF);
        chk("stall_imm",   {16'h0, id_imm16}, 32'hFFFF);
        chk("stall_addr",  imem_addr, 32'h10);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("unstall_req", {31'h0, imem_req}, 32'h1);

        // Redirect at PC=16 with memory not ready
        step(1, 0, 1, 32'h0000_0103, 0, 32'h0);
`ifdef DELAY_SLOT_EN
        chk("slot_addr", imem_addr, 32'h10);
        chk("slot_req",  {31'h0, imem_req}, 32'h1);
        step(1, 0, 0, 32'h0, 1, 32'hABCD_1234);
        chk("slot_valid", {31'h0, id_valid}, 32'h1);
        chk("slot_inst",  id_inst, 32'hABCD_1234);
        chk("slot_p4",    id_pc_plus4, 32'h14);
        chk("slot_tgt",   imem_addr, 32'h100);
`else
        chk("flush_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_addr",  imem_addr, 32'h100);
`endif

        // PC wrap at the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
`ifdef DELAY_SLOT_EN
        step(1, 0, 0, 32'h0, 1, 32'h5555_AAAA);
`endif
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0, 1, 32'h0C00_0001);
        chk("wrap_p4",   id_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset while a redirect is pending
        step(1, 0, 1, 32'h0000_0040, 0, 32'h0);
        async_reset();
        step(0, 0, 0, 32'h0, 1, 32'h7777_7777);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("post_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("post_rst_addr",  imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 255) == 0) begin
                async_reset();
                step(0, 0, 0, 32'h0, 1, $urandom);
            end else begin
                step(1,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom,
                     $urandom_range(0, 3) != 0,
                     $urandom);
            end
        end

        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
